// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// alu_pkg: opcode codes, FSM state encoding, NZCV flag indices and opcode classifiers for the ALU issue stage
package alu_pkg;
  localparam int OPC_W = 5;
  localparam logic [OPC_W-1:0] OP_NOP = 5'd0, OP_ANDS = 5'd1, OP_ORRS = 5'd2, OP_MVNS = 5'd3,
    OP_EORS = 5'd4, OP_ADDS = 5'd5, OP_SUBS = 5'd6, OP_RSBS = 5'd7, OP_SUB = 5'd8, OP_LSLS = 5'd9,
    OP_LSRS = 5'd10, OP_ASRS = 5'd11, OP_ADD = 5'd12, OP_AND = 5'd13, OP_MOV = 5'd14,
    OP_MVN = 5'd15, OP_NEG = 5'd16, OP_ABS = 5'd17, OP_CMP = 5'd18;
  localparam int FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return op >= OP_ANDS && op <= OP_CMP;
  endfunction
  function automatic logic is_single(input logic [OPC_W-1:0] op);
    return op == OP_MVNS || (op >= OP_MOV && op <= OP_ABS);
  endfunction
  function automatic logic updates_flags(input logic [OPC_W-1:0] op);
    return (op >= OP_ANDS && op <= OP_RSBS) || (op >= OP_LSLS && op <= OP_ASRS) || op == OP_CMP;
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
`timescale 1ns/1ps
// alu_issue_ctrl_if: op handshake, ALU drive/return, writeback, flags, error pulse and debug read port
interface alu_issue_ctrl_if #(parameter int DATA_W = 32, parameter int RA_W = 3, parameter int OP_W = 5);
  logic in_valid, in_ready, in_use_imm, wb_valid, err_illegal;
  logic [OP_W-1:0] in_op, alu_instr;
  logic [RA_W-1:0] in_rd, in_rn, in_rm, wb_rd, dbg_addr;
  logic [DATA_W-1:0] in_imm, alu_num1, alu_num2, alu_result, wb_data, dbg_data;
  logic [3:0] alu_flags, flags_q;
  modport slave (
    input in_valid, in_op, in_rd, in_rn, in_rm, in_use_imm, in_imm, alu_result, alu_flags, dbg_addr,
    output in_ready, alu_instr, alu_num1, alu_num2, wb_valid, wb_rd, wb_data, flags_q, err_illegal, dbg_data
  );
  modport master (
    output in_valid, in_op, in_rd, in_rn, in_rm, in_use_imm, in_imm, alu_result, alu_flags, dbg_addr,
    input in_ready, alu_instr, alu_num1, alu_num2, wb_valid, wb_rd, wb_data, flags_q, err_illegal, dbg_data
  );
endinterface

// File: rtl/alu_regfile.sv
`timescale 1ns/1ps
// alu_regfile: NREGS x DATA_W register file, three async reads (ra1/ra2/ra3), one sync write (we/wa/wd), async clear on rst
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS = 8,
  parameter int RA_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [RA_W-1:0]   ra1,
  input  logic [RA_W-1:0]   ra2,
  input  logic [RA_W-1:0]   ra3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3
);
  logic [DATA_W-1:0] mem [NREGS];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    else if (we) mem[wa] <= wd;
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
  assign rd3 = mem[ra3];
endmodule

// File: rtl/alu_issue_ctrl.sv
`timescale 1ns/1ps
// alu_issue_ctrl: serial issue/writeback stage around an external ALU; ports clk, rst, bus (op handshake, ALU drive, writeback, NZCV, error, debug read)
module alu_issue_ctrl import alu_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NREGS = 8,
  parameter int OP_W = 5,
  parameter int ALU_LAT = 1
) (
  input logic clk,
  input logic rst,
  alu_issue_ctrl_if.slave bus
);
  localparam int RA_W = $clog2(NREGS);
  localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [RA_W-1:0] rd_q;
  logic [DATA_W-1:0] rf_rn, rf_rm;
  logic [OP_W-1:0] op;
  logic acc, go, wr;
  assign op = bus.in_op;
  assign bus.in_ready = state == S_IDLE && !rst;
  assign acc = bus.in_valid && bus.in_ready;
  assign go = acc && is_alu_op(op);
  assign wr = state == S_WB && bus.alu_instr != OP_CMP;
  alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst(rst), .we(wr), .wa(rd_q), .wd(bus.alu_result),
    .ra1(bus.in_rn), .ra2(bus.in_rm), .ra3(bus.dbg_addr),
    .rd1(rf_rn), .rd2(rf_rm), .rd3(bus.dbg_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == S_IDLE ? (go ? S_EXEC : S_IDLE) : state == S_EXEC ? (cnt == '0 ? S_WB : S_EXEC) : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.alu_instr <= '0;
      bus.alu_num1 <= '0;
      bus.alu_num2 <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_rd <= '0;
      bus.wb_data <= '0;
      bus.flags_q <= '0;
      bus.err_illegal <= 1'b0;
      rd_q <= '0;
      cnt <= '0;
    end else begin
      bus.wb_valid <= wr;
      bus.err_illegal <= acc && op != OP_NOP && !is_alu_op(op);
      if (go) begin
        bus.alu_instr <= op;
        bus.alu_num1 <= rf_rn;
        bus.alu_num2 <= is_single(op) ? '0 : bus.in_use_imm ? bus.in_imm : rf_rm;
        rd_q <= bus.in_rd;
        cnt <= CW'(ALU_LAT - 1);
      end
      if (state == S_EXEC) cnt <= cnt - CW'(1);
      if (wr) begin
        bus.wb_rd <= rd_q;
        bus.wb_data <= bus.alu_result;
      end
      if (state == S_WB) begin
        bus.alu_instr <= '0;
        if (updates_flags(bus.alu_instr)) bus.flags_q <= bus.alu_flags;
      end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl at ALU_LAT 1 and 3 driven by a behavioural ALU
module tb_alu_issue_ctrl;
  typedef struct {int at; logic [2:0] rd; logic [31:0] data;} wb_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, checks = 0, failures = 0;
  logic [31:0] ref_rf [8];
  logic [3:0] ref_flags;
  wb_t exp_q[$], obs_q[$], obs3_q[$];
  alu_issue_ctrl_if b1();
  alu_issue_ctrl_if b3();
  alu_issue_ctrl #(.ALU_LAT(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  alu_issue_ctrl #(.ALU_LAT(3)) d3 (.clk(clk), .rst(rst), .bus(b3));
  always #1 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (b1.wb_valid) obs_q.push_back(wb_t'{cyc, b1.wb_rd, b1.wb_data});
    if (b3.wb_valid) obs3_q.push_back(wb_t'{cyc, b3.wb_rd, b3.wb_data});
  end
  function automatic logic [35:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = {1'b0, a} + {1'b0, b};
    c = 1'b0;
    v = 1'b0;
    case (op)
      5'd1, 5'd13: r = a & b;
      5'd2: r = a | b;
      5'd3, 5'd15: r = ~a;
      5'd4: r = a ^ b;
      5'd5, 5'd12: begin r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd6, 5'd8, 5'd18: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'd7: begin
        s = {1'b0, b} + {1'b0, ~a} + 33'd1; r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != b[31]);
      end
      5'd9: r = a << b[4:0];
      5'd10: r = a >> b[4:0];
      5'd11: r = $signed(a) >>> b[4:0];
      5'd14: r = a;
      5'd16: r = -a;
      5'd17: r = a[31] ? -a : a;
      default: r = '0;
    endcase
    return {r[31], r == 32'd0, c, v, r};
  endfunction
  assign {b1.alu_flags, b1.alu_result} = alu_model(b1.alu_instr, b1.alu_num1, b1.alu_num2);
  assign {b3.alu_flags, b3.alu_result} = alu_model(b3.alu_instr, b3.alu_num1, b3.alu_num2);
  function automatic bit writes_rd(input logic [4:0] op);
    return op >= 5'd1 && op <= 5'd17;
  endfunction
  function automatic bit sets_flags(input logic [4:0] op);
    return (op >= 5'd1 && op <= 5'd7) || (op >= 5'd9 && op <= 5'd11) || op == 5'd18;
  endfunction
  task automatic send1(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                       input logic ui, input logic [31:0] imm, output int acc, output int lows);
    logic [31:0] bv;
    logic [35:0] m;
    b1.in_op = op; b1.in_rd = rd; b1.in_rn = rn; b1.in_rm = rm; b1.in_use_imm = ui; b1.in_imm = imm;
    b1.in_valid = 1'b1;
    acc = -1;
    lows = 0;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      if (b1.in_ready) acc = cyc + 1;
      else lows++;
      @(negedge clk);
    end
    if (acc >= 0) begin
      bv = (op == 5'd3 || (op >= 5'd14 && op <= 5'd17)) ? 32'd0 : ui ? imm : ref_rf[rm];
      m = alu_model(op, ref_rf[rn], bv);
      if (writes_rd(op)) begin
        exp_q.push_back(wb_t'{acc + 2, rd, m[31:0]});
        ref_rf[rd] = m[31:0];
      end
      if (sets_flags(op)) ref_flags = m[35:32];
    end
  endtask
  task automatic send3(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rn,
                       input logic [31:0] imm, output int acc);
    b3.in_op = op; b3.in_rd = rd; b3.in_rn = rn; b3.in_rm = '0; b3.in_use_imm = 1'b1; b3.in_imm = imm;
    b3.in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      if (b3.in_ready) acc = cyc + 1;
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    int nbad;
    b1.in_valid = 0; b1.in_op = 0; b1.in_rd = 0; b1.in_rn = 0; b1.in_rm = 0; b1.in_use_imm = 0; b1.in_imm = 0; b1.dbg_addr = 0;
    b3.in_valid = 0; b3.in_op = 0; b3.in_rd = 0; b3.in_rn = 0; b3.in_rm = 0; b3.in_use_imm = 0; b3.in_imm = 0; b3.dbg_addr = 0;
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    ref_flags = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (b1.in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", b1.in_ready); end
    checks++;
    if (b1.wb_valid !== 1'b0 || b1.err_illegal !== 1'b0 || b1.flags_q !== 4'd0 || b1.alu_instr !== 5'd0 || b1.alu_num1 !== 32'd0) begin
      failures++; $display("FAIL reset_outs: wb=%b err=%b flags=%h instr=%0d num1=%h want all 0", b1.wb_valid, b1.err_illegal, b1.flags_q, b1.alu_instr, b1.alu_num1);
    end
    nbad = 0;
    for (int i = 0; i < 8; i++) begin b1.dbg_addr = 3'(i); #0.1; if (b1.dbg_data !== 32'd0) nbad++; end
    checks++; if (nbad != 0) begin failures++; $display("FAIL reset_regs: %0d nonzero regs, want 0", nbad); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (b1.in_ready !== 1'b1) begin failures++; $display("FAIL release_ready: got %b want 1", b1.in_ready); end
    checks++; if (b3.in_ready !== 1'b1) begin failures++; $display("FAIL release_ready3: got %b want 1", b3.in_ready); end
  endtask
  task automatic test_basic();
    int a, l;
    wb_t e, o;
    send1(5'd5, 3'd1, 3'd0, 3'd0, 1'b1, 32'd15, a, l);
    send1(5'd1, 3'd2, 3'd1, 3'd0, 1'b1, 32'd10, a, l);
    b1.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (obs_q.size() != 2 || exp_q.size() != 2) begin failures++; $display("FAIL basic_count: got %0d wb want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.at !== e.at || o.rd !== e.rd || o.data !== e.data) begin
        failures++; $display("FAIL basic_wb: got cyc%0d r%0d=%0d want cyc%0d r%0d=%0d", o.at, o.rd, o.data, e.at, e.rd, e.data);
      end
    end
    checks++; if (b1.flags_q !== ref_flags || b1.flags_q[3:2] !== 2'b00) begin failures++; $display("FAIL basic_flags: got %b want %b", b1.flags_q, ref_flags); end
    b1.dbg_addr = 3'd2; #0.1;
    checks++; if (b1.dbg_data !== 32'd10) begin failures++; $display("FAIL basic_r2: got %0d want 10", b1.dbg_data); end
  endtask
  task automatic test_cmp();
    int a, l;
    wb_t e, o;
    send1(5'd5, 3'd1, 3'd0, 3'd0, 1'b1, 32'd22, a, l);
    send1(5'd18, 3'd5, 3'd1, 3'd0, 1'b1, 32'd32, a, l);
    b1.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (obs_q.size() != 1 || exp_q.size() != 1) begin failures++; $display("FAIL cmp_count: got %0d wb want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.at !== e.at || o.rd !== e.rd || o.data !== e.data) begin
        failures++; $display("FAIL cmp_wb: got cyc%0d r%0d=%0d want cyc%0d r%0d=%0d", o.at, o.rd, o.data, e.at, e.rd, e.data);
      end
    end
    checks++; if (b1.flags_q !== ref_flags || {b1.flags_q[3], b1.flags_q[1]} !== 2'b10) begin failures++; $display("FAIL cmp_flags: got %b want %b", b1.flags_q, ref_flags); end
    b1.dbg_addr = 3'd1; #0.1;
    checks++; if (b1.dbg_data !== 32'd22) begin failures++; $display("FAIL cmp_r1: got %0d want 22", b1.dbg_data); end
    b1.dbg_addr = 3'd5; #0.1;
    checks++; if (b1.dbg_data !== 32'd0) begin failures++; $display("FAIL cmp_r5: got %0d want 0", b1.dbg_data); end
  endtask
  task automatic test_back_to_back();
    int a1, a2, l1, l2;
    wb_t e, o;
    @(negedge clk);
    send1(5'd5, 3'd3, 3'd0, 3'd0, 1'b1, 32'd7, a1, l1);
    send1(5'd2, 3'd6, 3'd3, 3'd0, 1'b1, 32'd8, a2, l2);
    b1.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (a2 - a1 != 3) begin failures++; $display("FAIL b2b_gap: got %0d cycles want 3", a2 - a1); end
    checks++; if (l2 != 2) begin failures++; $display("FAIL b2b_ready_low: got %0d cycles want 2", l2); end
    checks++; if (obs_q.size() != 2 || exp_q.size() != 2) begin failures++; $display("FAIL b2b_count: got %0d wb want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.at !== e.at || o.rd !== e.rd || o.data !== e.data) begin
        failures++; $display("FAIL b2b_wb: got cyc%0d r%0d=%0d want cyc%0d r%0d=%0d", o.at, o.rd, o.data, e.at, e.rd, e.data);
      end
    end
  endtask
  task automatic test_illegal();
    int a, l, n0, nbad;
    n0 = obs_q.size();
    send1(5'd25, 3'd1, 3'd1, 3'd1, 1'b1, 32'd99, a, l);
    checks++; if (b1.err_illegal !== 1'b1) begin failures++; $display("FAIL illegal_err: got %b want 1", b1.err_illegal); end
    checks++; if (b1.in_ready !== 1'b1) begin failures++; $display("FAIL illegal_ready: got %b want 1", b1.in_ready); end
    send1(5'd0, 3'd2, 3'd1, 3'd1, 1'b1, 32'd5, a, l);
    b1.in_valid = 1'b0;
    checks++; if (b1.err_illegal !== 1'b0) begin failures++; $display("FAIL illegal_pulse: got %b want 0", b1.err_illegal); end
    repeat (3) @(negedge clk);
    checks++; if (b1.in_ready !== 1'b1) begin failures++; $display("FAIL nop_ready: got %b want 1", b1.in_ready); end
    nbad = 0;
    for (int i = 0; i < 8; i++) begin b1.dbg_addr = 3'(i); #0.1; if (b1.dbg_data !== ref_rf[i]) nbad++; end
    checks++; if (nbad != 0) begin failures++; $display("FAIL illegal_regs: %0d regs changed, want 0", nbad); end
    checks++; if (b1.flags_q !== ref_flags) begin failures++; $display("FAIL illegal_flags: got %b want %b", b1.flags_q, ref_flags); end
    checks++; if (obs_q.size() != n0) begin failures++; $display("FAIL illegal_wb: got %0d wb want %0d", obs_q.size(), n0); end
  endtask
  task automatic test_reset_exec();
    int a, l, n0;
    @(negedge clk);
    n0 = obs_q.size();
    send1(5'd5, 3'd3, 3'd0, 3'd0, 1'b1, 32'd99, a, l);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (b1.in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", b1.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    b1.in_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    ref_flags = '0;
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() != n0) begin failures++; $display("FAIL rst_wb: got %0d wb want %0d", obs_q.size(), n0); end
    b1.dbg_addr = 3'd3; #0.1;
    checks++; if (b1.dbg_data !== 32'd0) begin failures++; $display("FAIL rst_r3: got %0d want 0", b1.dbg_data); end
    checks++; if (b1.in_ready !== 1'b1 || b1.flags_q !== 4'd0) begin failures++; $display("FAIL rst_after: ready=%b flags=%b want 1 0000", b1.in_ready, b1.flags_q); end
  endtask
  task automatic test_lat3();
    int a, asub;
    wb_t o;
    @(negedge clk);
    obs3_q.delete();
    send3(5'd5, 3'd5, 3'd0, 32'd16, a);
    send3(5'd18, 3'd7, 3'd0, 32'd1, a);
    send3(5'd8, 3'd4, 3'd5, 32'd4, asub);
    b3.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (obs3_q.size() != 2) begin failures++; $display("FAIL lat3_count: got %0d wb want 2", obs3_q.size()); end
    if (obs3_q.size() == 2) begin
      o = obs3_q.pop_front();
      checks++; if (o.rd !== 3'd5 || o.data !== 32'd16) begin failures++; $display("FAIL lat3_r5: got r%0d=%0d want r5=16", o.rd, o.data); end
      o = obs3_q.pop_front();
      checks++; if (o.rd !== 3'd4 || o.data !== 32'd12) begin failures++; $display("FAIL lat3_sub: got r%0d=%0d want r4=12", o.rd, o.data); end
      checks++; if (o.at - asub != 4) begin failures++; $display("FAIL lat3_latency: got %0d cycles want 4", o.at - asub); end
    end
    checks++; if (b3.flags_q !== 4'b1000) begin failures++; $display("FAIL lat3_flags: got %b want 1000", b3.flags_q); end
    b3.dbg_addr = 3'd4; #0.1;
    checks++; if (b3.dbg_data !== 32'd12) begin failures++; $display("FAIL lat3_r4: got %0d want 12", b3.dbg_data); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_cmp();
    test_back_to_back();
    test_illegal();
    test_reset_exec();
    test_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
